// File: rtl/decode_stage_pkg.sv
// Shared definitions for the RV32I-subset decode stage: opcodes, control
// encodings, immediate formats and the decode/execute register layout.
`default_nettype none

package decode_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_t;

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } de_reg_t;

  function automatic logic [XLEN-1:0] ext_imm(input logic [31:0] instr, input imm_src_t src);
    logic [XLEN-1:0] imm;
    case (src)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_register_file.sv
// Architectural register file: two combinational read ports with write-through
// bypass, one synchronous write port, x0 hardwired to zero, async active-low clear.
`default_nettype none

module register_file
  import decode_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);

  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic            w_wr_en;

  assign w_wr_en = i_we && (i_wa != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // A write landing this cycle is forwarded so decode sees the newest value.
  always_comb begin
    o_rd1 = r_regs[i_ra1];
    if (i_ra1 == 5'd0) begin
      o_rd1 = '0;
    end else if (w_wr_en && (i_wa == i_ra1)) begin
      o_rd1 = i_wd;
    end
  end

  always_comb begin
    o_rd2 = r_regs[i_ra2];
    if (i_ra2 == 5'd0) begin
      o_rd2 = '0;
    end else if (w_wr_en && (i_wa == i_ra2)) begin
      o_rd2 = i_wd;
    end
  end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// Decode stage: control decode, operand read, immediate extension and the
// decode/execute pipeline register.
`default_nettype none

module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        FlushE,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic        w_reg_write;
  logic        w_mem_write;
  logic        w_jump;
  logic        w_branch;
  logic        w_alu_src;
  logic [1:0]  w_result_src;
  logic [2:0]  w_alu_control;
  logic [2:0]  w_alu_op;
  logic        w_imm_en;
  imm_src_t    w_imm_src;
  de_reg_t     w_next;
  de_reg_t     r_e;

  assign w_opcode = InstrD[6:0];
  assign w_funct3 = InstrD[14:12];

  register_file u_register_file (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (InstrD[19:15]),
    .i_ra2 (InstrD[24:20]),
    .i_we  (RegWriteW),
    .i_wa  (RdW),
    .i_wd  (ResultW),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  // Subtract is only reachable from R-type; I-ALU with funct3=000 is addi.
  always_comb begin
    w_alu_op = ALU_ADD;
    case (w_funct3)
      3'b000:  w_alu_op = ((w_opcode == OP_RTYPE) && InstrD[30]) ? ALU_SUB : ALU_ADD;
      3'b010:  w_alu_op = ALU_SLT;
      3'b110:  w_alu_op = ALU_OR;
      3'b111:  w_alu_op = ALU_AND;
      default: w_alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    w_reg_write   = 1'b0;
    w_mem_write   = 1'b0;
    w_jump        = 1'b0;
    w_branch      = 1'b0;
    w_alu_src     = 1'b0;
    w_result_src  = RES_ALU;
    w_alu_control = ALU_ADD;
    w_imm_en      = 1'b0;
    w_imm_src     = IMM_I;
    case (w_opcode)
      OP_LOAD: begin
        w_reg_write  = 1'b1;
        w_alu_src    = 1'b1;
        w_result_src = RES_MEM;
        w_imm_en     = 1'b1;
        w_imm_src    = IMM_I;
      end
      OP_STORE: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm_en    = 1'b1;
        w_imm_src   = IMM_S;
      end
      OP_RTYPE: begin
        w_reg_write   = 1'b1;
        w_alu_control = w_alu_op;
      end
      OP_IALU: begin
        w_reg_write   = 1'b1;
        w_alu_src     = 1'b1;
        w_alu_control = w_alu_op;
        w_imm_en      = 1'b1;
        w_imm_src     = IMM_I;
      end
      OP_BRANCH: begin
        w_branch      = 1'b1;
        w_alu_control = ALU_SUB;
        w_imm_en      = 1'b1;
        w_imm_src     = IMM_B;
      end
      OP_JAL: begin
        w_reg_write  = 1'b1;
        w_jump       = 1'b1;
        w_result_src = RES_PC4;
        w_imm_en     = 1'b1;
        w_imm_src    = IMM_J;
      end
      default: begin
        w_reg_write = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_next             = '0;
    w_next.reg_write   = w_reg_write;
    w_next.mem_write   = w_mem_write;
    w_next.jump        = w_jump;
    w_next.branch      = w_branch;
    w_next.alu_src     = w_alu_src;
    w_next.result_src  = w_result_src;
    w_next.alu_control = w_alu_control;
    w_next.rd1         = w_rd1;
    w_next.rd2         = w_rd2;
    w_next.imm_ext     = w_imm_en ? ext_imm(InstrD, w_imm_src) : '0;
    w_next.rs1         = InstrD[19:15];
    w_next.rs2         = InstrD[24:20];
    w_next.rd          = InstrD[11:7];
    w_next.pc          = PCD;
    w_next.pc_plus4    = PCPlus4D;
  end

  // Flush wins over the new decode and turns the whole register into a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_e <= '0;
    end else if (FlushE) begin
      r_e <= '0;
    end else begin
      r_e <= w_next;
    end
  end

  assign RegWriteE   = r_e.reg_write;
  assign MemWriteE   = r_e.mem_write;
  assign JumpE       = r_e.jump;
  assign BranchE     = r_e.branch;
  assign ALUSrcE     = r_e.alu_src;
  assign ResultSrcE  = r_e.result_src;
  assign ALUControlE = r_e.alu_control;
  assign RD1E        = r_e.rd1;
  assign RD2E        = r_e.rd2;
  assign ImmExtE     = r_e.imm_ext;
  assign Rs1E        = r_e.rs1;
  assign Rs2E        = r_e.rs2;
  assign RdE         = r_e.rd;
  assign PCE         = r_e.pc;
  assign PCPlus4E    = r_e.pc_plus4;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed cases plus randomized traffic
// checked against a behavioural decode model and a shadow register array.
`default_nettype none

module tb_decode_stage;

  typedef struct packed {
    logic        rw, mw, j, b, as;
    logic [1:0]  rs;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
  logic        FlushE = 1'b0, RegWriteW = 1'b0;
  logic [4:0]  RdW = '0;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;

  int checks = 0;
  int errors = 0;
  exp_t        sb_q[$];
  logic [31:0] mregs [32];
  logic [31:0] pc_cur = 32'h0000_1000;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << bits;
    return v[bits-1] ? (v | m) : (v & ~m);
  endfunction

  // Operand value as architecturally visible this cycle, including a same-cycle write.
  function automatic logic [31:0] opval(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (RegWriteW && RdW == idx) return ResultW;
    return mregs[idx];
  endfunction

  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [2:0] aluop;
    logic [31:0] raw;
    e = '0;
    if (!rst || FlushE) return e;
    op = ins[6:0];
    f3 = ins[14:12];
    if (f3 == 3'd0 && op == 7'h33 && ins[30]) aluop = 3'b001;
    else if (f3 == 3'd2) aluop = 3'b101;
    else if (f3 == 3'd6) aluop = 3'b011;
    else if (f3 == 3'd7) aluop = 3'b010;
    else aluop = 3'b000;
    e.rd1 = opval(ins[19:15]);
    e.rd2 = opval(ins[24:20]);
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.pc  = PCD;
    e.pc4 = PCPlus4D;
    if (op == 7'h03) begin
      e.rw = 1; e.as = 1; e.rs = 2'b01;
      e.imm = sext(32'(ins >> 20), 12);
    end else if (op == 7'h23) begin
      e.mw = 1; e.as = 1;
      raw = ((ins >> 25) << 5) | ((ins >> 7) & 32'h1F);
      e.imm = sext(raw, 12);
    end else if (op == 7'h33) begin
      e.rw = 1; e.alu = aluop;
    end else if (op == 7'h13) begin
      e.rw = 1; e.as = 1; e.alu = aluop;
      e.imm = sext(32'(ins >> 20), 12);
    end else if (op == 7'h63) begin
      e.b = 1; e.alu = 3'b001;
      raw = (32'(ins[31]) << 12) | (32'(ins[7]) << 11) |
            (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      e.imm = sext(raw, 13);
    end else if (op == 7'h6F) begin
      e.rw = 1; e.j = 1; e.rs = 2'b10;
      raw = (32'(ins[31]) << 20) | (32'(ins[19:12]) << 12) |
            (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      e.imm = sext(raw, 21);
    end
    return e;
  endfunction

  task automatic cycle(input logic rstv, input logic [31:0] ins, input logic fl,
                       input logic we, input logic [4:0] rdw, input logic [31:0] wd);
    @(negedge clk);
    rst = rstv; InstrD = ins; PCD = pc_cur; PCPlus4D = pc_cur + 32'd4;
    FlushE = fl; RegWriteW = we; RdW = rdw; ResultW = wd;
    sb_q.push_back(model(ins));
    if (!rstv) begin
      for (int i = 0; i < 32; i++) mregs[i] = '0;
    end else if (we && rdw != 0) begin
      mregs[rdw] = wd;
    end
    pc_cur = pc_cur + 32'd4;
    @(posedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("RegWriteE",   32'(RegWriteE),   32'(e.rw));
        chk("MemWriteE",   32'(MemWriteE),   32'(e.mw));
        chk("JumpE",       32'(JumpE),       32'(e.j));
        chk("BranchE",     32'(BranchE),     32'(e.b));
        chk("ALUSrcE",     32'(ALUSrcE),     32'(e.as));
        chk("ResultSrcE",  32'(ResultSrcE),  32'(e.rs));
        chk("ALUControlE", 32'(ALUControlE), 32'(e.alu));
        chk("RD1E",        RD1E,             e.rd1);
        chk("RD2E",        RD2E,             e.rd2);
        chk("ImmExtE",     ImmExtE,          e.imm);
        chk("Rs1E",        32'(Rs1E),        32'(e.rs1));
        chk("Rs2E",        32'(Rs2E),        32'(e.rs2));
        chk("RdE",         32'(RdE),         32'(e.rd));
        chk("PCE",         PCE,              e.pc);
        chk("PCPlus4E",    PCPlus4E,         e.pc4);
      end
    end
  end

  initial begin : stim
    logic [31:0] r, ins;
    logic [6:0]  ops [7];
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h00};
    for (int i = 0; i < 32; i++) mregs[i] = '0;

    // Reset held with addi x1,x0,5 on the input.
    repeat (3) cycle(1'b0, 32'h0050_0093, 1'b0, 1'b1, 5'd4, 32'hDEAD);
    cycle(1'b1, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("gold addi RegWriteE", 32'(RegWriteE), 32'd1);
    chk("gold addi ImmExtE", ImmExtE, 32'd5);
    chk("gold addi RdE", 32'(RdE), 32'd1);
    chk("gold addi ALUSrcE", 32'(ALUSrcE), 32'd1);

    // Write-through then stored read of x1.
    cycle(1'b1, 32'h0020_81B3, 1'b0, 1'b1, 5'd1, 32'h1234);
    #2; chk("gold bypass RD1E", RD1E, 32'h1234);
    cycle(1'b1, 32'h0020_81B3, 1'b0, 1'b0, 5'd0, 32'd0);
    #2; chk("gold stored RD1E", RD1E, 32'h1234);

    // x0 stays zero.
    cycle(1'b1, 32'h0000_0013, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    cycle(1'b1, 32'h0000_02B3, 1'b0, 1'b0, 5'd0, 32'd0);
    #2; chk("gold x0 RD1E", RD1E, 32'd0); chk("gold x0 RD2E", RD2E, 32'd0);

    cycle(1'b1, 32'hFE20_AE23, 1'b0, 1'b0, 5'd0, 32'd0);
    #2; chk("gold sw ImmExtE", ImmExtE, 32'hFFFF_FFFC); chk("gold sw MemWriteE", 32'(MemWriteE), 32'd1);
    cycle(1'b1, 32'hFE20_8CE3, 1'b0, 1'b0, 5'd0, 32'd0);
    #2; chk("gold beq ImmExtE", ImmExtE, 32'hFFFF_FFF8); chk("gold beq ALUControlE", 32'(ALUControlE), 32'd1);
    cycle(1'b1, 32'h0010_00EF, 1'b0, 1'b0, 5'd0, 32'd0);
    #2; chk("gold jal ImmExtE", ImmExtE, 32'h0000_0800); chk("gold jal ResultSrcE", 32'(ResultSrcE), 32'd2);

    // Flush with a simultaneous write to x7, then read x7.
    cycle(1'b1, 32'h0000_A183, 1'b1, 1'b1, 5'd7, 32'hCAFE_0007);
    #2; chk("gold flush RegWriteE", 32'(RegWriteE), 32'd0); chk("gold flush ResultSrcE", 32'(ResultSrcE), 32'd0);
    cycle(1'b1, 32'h0003_8433, 1'b0, 1'b0, 5'd0, 32'd0);
    #2; chk("gold x7 RD1E", RD1E, 32'hCAFE_0007);

    cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 32'd0);
    #2; chk("gold undef RegWriteE", 32'(RegWriteE), 32'd0); chk("gold undef PCE", PCE, pc_cur - 32'd4);

    for (int n = 0; n < 400; n++) begin
      r   = $urandom();
      ins = {r[31:7], ops[$urandom_range(0, 6)]};
      if ($urandom_range(0, 9) == 0) ins = $urandom();
      if (n == 200) begin
        // Asynchronous reset in mid-cycle must clear outputs without a clock edge.
        @(negedge clk); #2; rst = 1'b0; #1;
        chk("async reset outputs", 32'({RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
            ResultSrcE, ALUControlE} != 0 || RD1E != 0 || ImmExtE != 0 || PCE != 0), 32'd0);
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        cycle(1'b0, ins, 1'b0, 1'b1, 5'd3, r);
      end
      cycle(1'b1, ins, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 1) != 0) ? ins[19:15] : 5'($urandom()), $urandom());
    end

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
